// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the MEM-stage data port: one access at a time, fixed latency.
// Optional misalignment checking is compiled in with `define DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    inout  wire  [31:0] ddata,
    output logic        dready_n,
    output logic        dbusy,
    output logic        derr
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                run;
    logic                accept;
    logic                enter_done;
    logic                req_bad;
    logic                wr_q;
    logic                bad_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata;
    logic                op_wr;
    logic                op_bad;
    logic [ADDR_W-1:0]   op_idx;
    logic [31:0]         op_wdata;
    logic                unused_addr;
    logic [31:0]         mem [0:(2**ADDR_W)-1];

`ifdef DMEM_MISALIGN_CHK_EN
    assign req_bad     = (daddr[1:0] != 2'b00);
    assign unused_addr = ^daddr[31:ADDR_W+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            derr <= 1'b0;
        end else if (accept && req_bad) begin
            derr <= 1'b1;
        end
    end
`else
    assign req_bad     = 1'b0;
    assign derr        = 1'b0;
    assign unused_addr = ^{daddr[31:ADDR_W+2], daddr[1:0]};
`endif

    // run stays low for the first edge after reset release, so nothing is accepted or
    // committed on an edge that the async reset was still holding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run   <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            wr_q  <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q  <= dwrite;
                bad_q <= req_bad;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        dready_n  = 1'b1;
        dbusy     = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && run) begin
                    accept  = 1'b1;
                    cnt_nxt = dwrite ? WR_CNT : RD_CNT;
                    if ((dwrite ? WR_LAT : RD_LAT) > 1) begin
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            BUSY: begin
                dbusy = 1'b1;
                if (cnt <= CNT_ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DONE: begin
                dready_n  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With a one-cycle latency the commit edge is the acceptance edge, so the
    // operation comes straight from the port rather than the capture registers.
    assign enter_done = (state_nxt == DONE);
    assign op_wr      = accept ? dwrite : wr_q;
    assign op_bad     = accept ? req_bad : bad_q;
    assign op_idx     = accept ? daddr[ADDR_W+1:2] : idx_q;
    assign op_wdata   = accept ? ddata : wdata_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= daddr[ADDR_W+1:2];
            wdata_q <= ddata;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_done) begin
            if (op_wr) begin
                if (!op_bad) begin
                    mem[op_idx] <= op_wdata;
                end
            end else begin
                rdata <= op_bad ? BAD_WORD : mem[op_idx];
            end
        end
    end

    assign ddata = (state == DONE && !wr_q) ? rdata : {32{1'bz}};

endmodule
